// File: rtl/fifo_pkg.sv
// Shared defaults and pointer-width helper for the single-clock FIFO.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 8;

  // One extra wrap bit above the array address distinguishes full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: unreset storage, one write port, registered read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset; it holds between accepted reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/synchronous_fifo.sv
// Single-clock FIFO: wrap-bit pointers, flag decode and accept gating around fifo_mem.
module synchronous_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH    // power of two, >= 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W  = ptr_w(DEPTH);
  localparam int ADDR_W = PTR_W - 1;

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             wr_ok;
  logic             rd_ok;

  // Flags decode registered pointers only, so they never glitch mid-cycle.
  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) && (wptr[ADDR_W] != rptr[ADDR_W]);

  assign wr_ok = w_en && !full;
  assign rd_ok = r_en && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + PTR_W'(1);
      if (rd_ok) rptr <= rptr + PTR_W'(1);
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wptr[ADDR_W-1:0]),
    .wdata (data_in),
    .re    (rd_ok),
    .raddr (rptr[ADDR_W-1:0]),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_synchronous_fifo.sv
// Randomized and directed bench for synchronous_fifo against a queue-based reference model.
module tb_synchronous_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          w_en = 1'b0;
  logic          r_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] model_q [$];
  logic [DW-1:0] model_dout = '0;

  synchronous_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .w_en     (w_en),
    .r_en     (r_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".data_out"}, 32'(data_out), 32'(model_dout));
    chk({tag, ".empty"},    32'(empty),    32'(model_q.size() == 0));
    chk({tag, ".full"},     32'(full),     32'(model_q.size() == DEPTH));
  endtask

  // One clock: drive, let the edge happen, advance the model, compare 1 ns later.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
    bit wr, rd;
    w_en = w; r_en = r; data_in = d;
    @(posedge clk);
    if (!rst) begin
      model_q.delete();
      model_dout = '0;
    end else begin
      wr = w && (model_q.size() < DEPTH);
      rd = r && (model_q.size() > 0);
      if (rd) model_dout = model_q.pop_front();
      if (wr) model_q.push_back(d);
    end
    #1;
    chk_all(tag);
  endtask

  initial begin
    // Reset with random enables
    rst = 1'b0;
    for (int i = 0; i < 2; i++)
      step(1'($urandom), 1'($urandom), DW'($urandom), "reset_hold");
    rst = 1'b1;
    step(1'b0, 1'b0, '0, "reset_release");

    // Basic ordering
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, DW'(10 * i), "basic_wr");
    step(1'b0, 1'b0, '0, "basic_idle");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0, "basic_rd");
    chk("basic_last", 32'(data_out), 32'd40);
    step(1'b0, 1'b0, '0, "basic_hold");

    // Underflow
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, "underflow_rd");
    chk("underflow_hold", 32'(data_out), 32'd40);
    step(1'b1, 1'b0, DW'(55), "underflow_wr55");
    step(1'b0, 1'b1, '0, "underflow_rd55");
    chk("underflow_55", 32'(data_out), 32'd55);

    // Full boundary
    for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, DW'(i), "full_wr");
    chk("full_flag", 32'(full), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, '0, "full_rd");
      chk("full_order", 32'(data_out), 32'(i));
    end
    chk("full_drained", 32'(empty), 32'd1);

    // Simultaneous traffic across the pointer wrap
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(i), "sim_preload");
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, DW'(100 + i), "sim_rw");
      chk("sim_occupancy", 32'(model_q.size()), 32'd3);
      chk("sim_seq", 32'(data_out), (i < 3) ? 32'(i) : 32'(100 + i - 3));
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, "sim_drain");
    chk("sim_tail", 32'(data_out), 32'd119);

    // Full with both enables: read wins, write dropped
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(200 + i), "fullrw_fill");
    step(1'b1, 1'b1, DW'(250), "fullrw_both");
    chk("fullrw_dout", 32'(data_out), 32'd200);
    chk("fullrw_notfull", 32'(full), 32'd0);
    while (model_q.size() > 0) step(1'b0, 1'b1, '0, "fullrw_drain");
    chk("fullrw_last", 32'(data_out), 32'd207);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
           DW'($urandom), "random");

    // Asynchronous reset mid-operation
    while (model_q.size() > 0) step(1'b0, 1'b1, '0, "mid_predrain");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(60 + i), "mid_load");
    step(1'b0, 1'b1, '0, "mid_rd");
    #2;
    rst = 1'b0;
    #1;
    model_q.delete();
    model_dout = '0;
    chk_all("mid_async");
    step(1'b1, 1'b1, DW'(9), "mid_inreset");
    rst = 1'b1;
    step(1'b1, 1'b0, DW'(77), "mid_wr77");
    step(1'b0, 1'b1, '0, "mid_rd77");
    chk("mid_77", 32'(data_out), 32'd77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
